// File: rtl/i2c_write_target.sv
// I2C write-only target: oversamples SCLK/SDAT, ACKs address + two data bytes,
// and strobes the 16-bit word out on the ACK release that ends the second data byte.
module i2c_write_target #(
  parameter logic [6:0] ADDR        = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        frame_err
);

  // state      | meaning
  // S_IDLE     | bus free, waiting for START
  // S_ADDR     | shifting in the address byte
  // S_ADDR_ACK | address matched: drive ACK on next fall, release on the one after
  // S_DATA     | shifting in a data byte
  // S_DATA_ACK | ACK slot for a data byte; the second one commits rx_data
  // S_IGNORE   | not addressed / frame done: wait for STOP or repeated START
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdat_sync_q;
  logic                   sclk_prev_q, sdat_prev_q;
  logic                   sclk_s, sdat_s;
  logic                   sclk_rise, sclk_fall, start_det, stop_det;

  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic        ack_drv_q, ack_drv_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        in_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '1;
      sdat_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      sdat_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2c_sclk};
      sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], i2c_sdat};
      sclk_prev_q <= sclk_s;
      sdat_prev_q <= sdat_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdat_s    = sdat_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // Requiring SCLK high in both samples keeps a data change right at a falling edge from looking like START/STOP.
  assign start_det = sclk_s & sclk_prev_q & sdat_prev_q & ~sdat_s;
  assign stop_det  = sclk_s & sclk_prev_q & ~sdat_prev_q & sdat_s;

  assign in_frame = (state_q == S_ADDR_ACK) || (state_q == S_DATA) || (state_q == S_DATA_ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      ack_drv_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      ack_drv_q   <= ack_drv_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    ack_drv_d   = ack_drv_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (start_det) begin
      frame_err_d = in_frame;
      state_d     = S_ADDR;
      shift_d     = '0;
      bit_cnt_d   = '0;
      byte_cnt_d  = '0;
      ack_drv_d   = 1'b0;
    end else if (stop_det) begin
      frame_err_d = in_frame;
      state_d     = S_IDLE;
      ack_drv_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], sdat_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if ((shift_d[7:1] == ADDR) && !shift_d[0]) state_d = S_ADDR_ACK;
              else                                       state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (sclk_fall) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              bit_cnt_d = '0;
              if ((state_q == S_DATA_ACK) && (byte_cnt_q == 2'd2)) begin
                rx_data_d  = {hi_q, lo_q};
                rx_valid_d = 1'b1;
                state_d    = S_IGNORE;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[6:0], sdat_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              case (byte_cnt_q)
                2'd0: begin
                  hi_d       = shift_d;
                  byte_cnt_d = 2'd1;
                  state_d    = S_DATA_ACK;
                end
                2'd1: begin
                  lo_d       = shift_d;
                  byte_cnt_d = 2'd2;
                  state_d    = S_DATA_ACK;
                end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_sdat  = ack_drv_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_write_target.sv
// Directed bench for i2c_write_target: bit-banged controller on a pulled-up SDAT line.
module tb_i2c_write_target;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sclk = 1'b1;
  logic        sda_low = 1'b0;
  wire         sdat;
  logic [15:0] rx_data;
  logic        rx_valid, busy, frame_err;

  int ntests = 0;
  int nfail  = 0;
  int valid_cyc = 0;
  int ferr_cyc  = 0;
  int v0, f0;
  logic a;

  pullup (sdat);
  assign sdat = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_target #(.ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2c_sclk  (sclk),
    .i2c_sdat  (sdat),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) valid_cyc++;
    if (frame_err === 1'b1) ferr_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works both from idle bus and as a repeated START from SCLK low.
  task automatic i2c_start();
    sda_low = 1'b0; wclk(P);
    sclk = 1'b1;    wclk(P);
    sda_low = 1'b1; wclk(P);
    sclk = 1'b0;    wclk(2);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wclk(P);
    sclk = 1'b1;    wclk(P);
    sda_low = 1'b0; wclk(P);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; wclk(P);
    sclk = 1'b1;  wclk(P);
    sclk = 1'b0;  wclk(2);
  endtask

  // ack = 0 means the target pulled SDAT low during the ninth clock.
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_low = 1'b0; wclk(P);
    sclk = 1'b1;    wclk(P/2);
    ack = sdat;     wclk(P/2);
    sclk = 1'b0;    wclk(2);
  endtask

  initial begin
    wclk(3);
    check("reset rx_data", rx_data, 32'h0);
    check("reset rx_valid", rx_valid, 32'h0);
    check("reset busy", busy, 32'h0);
    check("reset frame_err", frame_err, 32'h0);
    check("reset sdat released", sdat, 32'h1);
    reset_n = 1'b1;
    wclk(4);

    // Full write 0x34, 0x42, 0xF2
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    check("busy after start", busy, 32'h1);
    send_byte(8'h34, a); check("w1 addr ack", a, 32'h0);
    send_byte(8'h42, a); check("w1 d0 ack", a, 32'h0);
    send_byte(8'hF2, a); check("w1 d1 ack", a, 32'h0);
    i2c_stop();
    check("w1 rx_data", rx_data, 32'h42F2);
    check("w1 rx_valid cycles", valid_cyc - v0, 32'd1);
    check("w1 frame_err cycles", ferr_cyc - f0, 32'd0);
    check("w1 busy after stop", busy, 32'h0);

    // Address mismatch
    v0 = valid_cyc;
    i2c_start();
    send_byte(8'h3A, a); check("mm addr nack", a, 32'h1);
    send_byte(8'h42, a); check("mm d0 nack", a, 32'h1);
    send_byte(8'hF2, a); check("mm d1 nack", a, 32'h1);
    i2c_stop();
    check("mm rx_valid cycles", valid_cyc - v0, 32'd0);
    check("mm rx_data kept", rx_data, 32'h42F2);
    check("mm busy after stop", busy, 32'h0);

    // Read request is NACKed
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    send_byte(8'h35, a); check("rd addr nack", a, 32'h1);
    send_byte(8'h42, a); check("rd d0 nack", a, 32'h1);
    i2c_stop();
    check("rd rx_valid cycles", valid_cyc - v0, 32'd0);
    check("rd frame_err cycles", ferr_cyc - f0, 32'd0);

    // Truncated frame
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    send_byte(8'h34, a); check("tr addr ack", a, 32'h0);
    send_byte(8'hAA, a); check("tr d0 ack", a, 32'h0);
    i2c_stop();
    check("tr frame_err cycles", ferr_cyc - f0, 32'd1);
    check("tr rx_valid cycles", valid_cyc - v0, 32'd0);
    check("tr rx_data kept", rx_data, 32'h42F2);
    check("tr busy after stop", busy, 32'h0);

    // Repeated START mid-frame, then a complete write
    v0 = valid_cyc; f0 = ferr_cyc;
    i2c_start();
    send_byte(8'h34, a); check("rs addr ack", a, 32'h0);
    send_byte(8'h11, a); check("rs d0 ack", a, 32'h0);
    i2c_start();
    check("rs frame_err at restart", ferr_cyc - f0, 32'd1);
    check("rs busy after restart", busy, 32'h1);
    send_byte(8'h34, a); check("rs2 addr ack", a, 32'h0);
    send_byte(8'h55, a); check("rs2 d0 ack", a, 32'h0);
    send_byte(8'h66, a); check("rs2 d1 ack", a, 32'h0);
    i2c_stop();
    check("rs rx_valid cycles", valid_cyc - v0, 32'd1);
    check("rs rx_data", rx_data, 32'h5566);
    check("rs frame_err total", ferr_cyc - f0, 32'd1);

    // Reset during the first data byte's ACK
    i2c_start();
    send_byte(8'h34, a); check("rst addr ack", a, 32'h0);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    sda_low = 1'b0; wclk(P);
    sclk = 1'b1;    wclk(P/2);
    check("rst ack driven", sdat, 32'h0);
    reset_n = 1'b0;
    #1;
    check("rst sdat released", sdat, 32'h1);
    check("rst rx_data", rx_data, 32'h0);
    check("rst rx_valid", rx_valid, 32'h0);
    check("rst busy", busy, 32'h0);
    check("rst frame_err", frame_err, 32'h0);
    wclk(2);
    reset_n = 1'b1;
    wclk(P);
    sclk = 1'b0; wclk(P);
    i2c_stop();

    v0 = valid_cyc;
    i2c_start();
    send_byte(8'h34, a); check("pr addr ack", a, 32'h0);
    send_byte(8'h12, a); check("pr d0 ack", a, 32'h0);
    send_byte(8'h34, a); check("pr d1 ack", a, 32'h0);
    i2c_stop();
    check("pr rx_data", rx_data, 32'h1234);
    check("pr rx_valid cycles", valid_cyc - v0, 32'd1);
    check("pr busy after stop", busy, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/i2c_write_target.md
Name: i2c_write_target

Overview:
Synthesizable I2C target (responder) for the write-only 3-byte transactions issued by i2c_controller: one address byte, then two data bytes, MSB first.
- Oversamples SCLK/SDAT on the system clock.
- ACKs matching bytes.
- Delivers the 16-bit data word as a one-cycle strobe.
- Serves as the on-chip register-port endpoint and as a synthesizable replacement for behavioural bench targets.

Parameters:
ADDR, 7'h1A, 7-bit target address matched against address byte bits [7:1]
SYNC_STAGES, 2, synchronizer flops on i2c_sclk and i2c_sdat input paths (min 2)

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
i2c_sclk  input  1  I2C clock from controller
i2c_sdat  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1
rx_data  output  16  {data byte 1, data byte 2} of the last accepted write
rx_valid  output  1  one-cycle strobe, rx_data newly updated
busy  output  1  high from START detect until STOP or return to IDLE
frame_err  output  1  one-cycle strobe on STOP/START inside an incomplete accepted frame

Behaviour:
- Reset values (asynchronous): rx_data=0, rx_valid=0, busy=0, frame_err=0, sdat released (z), state=IDLE, sync flops=1 (idle bus). Reset mid-frame releases SDAT immediately.
- Edges are derived from synchronized samples and previous synchronized samples.
  - sclk_rise, sclk_fall.
  - START: sdat falls while sclk high.
  - STOP: sdat rises while sclk high.
- START and STOP take priority over bit sampling in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE -> ADDR on START; clear shift register, bit_cnt=0, byte_cnt=0, busy=1.
- ADDR: shift in sdat on each sclk_rise. After 8th bit:
  - match is byte[7:1]==ADDR and byte[0]==0 (write only).
  - match: ADDR_ACK.
  - otherwise: IGNORE (no ACK; reads are NACKed).
- ADDR_ACK/DATA_ACK:
  - On the next sclk_fall, drive sdat=0.
  - Hold 0 through that ACK clock high.
  - Release sdat on the following sclk_fall.
  - Then go to DATA (bit_cnt=0), except as noted below.
- DATA: shift 8 bits on sclk_rise.
  - byte_cnt 0: store high byte -> DATA_ACK.
  - byte_cnt 1: store low byte -> DATA_ACK.
  - byte_cnt 2 (extra byte): -> IGNORE, no ACK.
- Commit: on the release sclk_fall ending the byte-2 ACK:
  - rx_data <= {hi,lo}; rx_valid=1 for exactly one clk.
  - state -> IGNORE (awaiting STOP).
- IGNORE: sdat released; wait for STOP (-> IDLE, busy=0) or START (-> ADDR).
- STOP in any state -> IDLE, busy=0, sdat released.
- START in any non-IDLE state (repeated start) -> ADDR with counters cleared.
- frame_err=1 for one clk when STOP/START arrives after an address ACK but before commit. In that case rx_data is unchanged and there is no rx_valid.
- Bits are sampled only on sclk_rise. SDAT changes while SCLK is high are treated only as START/STOP.
- Timing: SCLK must stay high/low at least SYNC_STAGES+2 clk cycles per phase. Faster buses are out of spec.
- rx_data holds its value until the next commit; no back-pressure.

Test Plan:
- Write bytes 0x34,0x42,0xF2, then STOP:
  - SDAT low in all three ACK slots.
  - rx_data=16'h42F2; rx_valid high exactly 1 clk.
  - busy falls after STOP.
- Address byte 0x3A (ADDR mismatch): SDAT stays high in every slot, no rx_valid, rx_data unchanged, busy=0 after STOP.
- Address byte 0x35 (read): NACK at address slot, no further ACKs, no rx_valid.
- 0x34,0xAA then STOP: two ACKs, frame_err 1-clk pulse, no rx_valid, rx_data keeps 16'h42F2.
- Repeated START after 0x34,0x11, then 0x34,0x55,0x66,STOP: single rx_valid, rx_data=16'h5566, frame_err pulse at repeated START.
- reset_n low mid-ACK of byte 1: SDAT released same cycle, all outputs 0. Next full write 0x34,0x12,0x34 yields rx_data=16'h1234.
